prng_gold: RTL and testbench

Parametrised Gold-code chip generator, the successor to the single-LFSR PRN source in the GPS signal generator. Two Fibonacci LFSRs (G1, G2) combine through a runtime-selectable G2 phase-tap pair to produce GPS C/A-style codes. The code period is programmable, and the block emits an epoch strobe at each code restart. It sits between the chip-rate enable generator and the BPSK modulator, so the same RTL produces any PRN without re-synthesis.

---
 rtl/prng_gold.sv | 74 +++++++
 tb/tb_prng_gold.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prng_gold.sv
// prng_gold: Gold-code chip generator (G1 ^ phase-tapped G2) with programmable period and epoch strobe.
// Define PRNG_GOLD_BIT_SYNC_EN to add the 20-epoch nav-bit start strobe on bit_start_out.
module prng_gold #(
  parameter int                N_BITS     = 10,
  parameter logic [N_BITS-1:0] POLY1      = 10'h204,
  parameter logic [N_BITS-1:0] POLY2      = 10'h3A6,
  parameter logic [N_BITS-1:0] SEED1      = '1,
  parameter logic [N_BITS-1:0] SEED2      = '1,
  parameter int                CODE_LEN   = 1023,
  parameter int                OUT_BITS   = 4,
  parameter int                TAP_A_INIT = 2,
  parameter int                TAP_B_INIT = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                ena_in,
  input  logic                tap_load_in,
  input  logic [4:0]          tap_a_in,
  input  logic [4:0]          tap_b_in,
  output logic                chip_out,
  output logic [OUT_BITS-1:0] chip_signed_out,
  output logic [N_BITS-1:0]   chip_idx_out,
  output logic                epoch_out,
  output logic                bit_start_out
);
  logic [N_BITS-1:0] g1, g2, chip_idx;
  logic [4:0]        tap_a, tap_b;
  logic              g2_a, g2_b, wrap;
  assign wrap = chip_idx == N_BITS'(CODE_LEN - 1);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tap_a <= 5'(TAP_A_INIT);
      tap_b <= 5'(TAP_B_INIT);
    end else if (tap_load_in) begin
      tap_a <= tap_a_in;
      tap_b <= tap_b_in;
    end
  end
  // Reload on wrap rather than shift so periods shorter than the m-sequence stay exact.
  always_ff @(posedge clk_in) begin
    if (rst_in || tap_load_in || (ena_in && wrap)) begin
      g1       <= SEED1;
      g2       <= SEED2;
      chip_idx <= '0;
    end else if (ena_in) begin
      g1       <= {g1[N_BITS-2:0], ^(g1 & POLY1)};
      g2       <= {g2[N_BITS-2:0], ^(g2 & POLY2)};
      chip_idx <= chip_idx + 1'b1;
    end
  end
  // Out-of-range tap indices match no stage and so contribute 0.
  always_comb begin
    g2_a = 1'b0;
    g2_b = 1'b0;
    for (int i = 0; i < N_BITS; i++) begin
      if (tap_a == 5'(i + 1)) g2_a = g2[i];
      if (tap_b == 5'(i + 1)) g2_b = g2[i];
    end
  end
  assign chip_out        = g1[N_BITS-1] ^ g2_a ^ g2_b;
  assign chip_signed_out = chip_out ? '1 : OUT_BITS'(1);
  assign chip_idx_out    = chip_idx;
  assign epoch_out       = ena_in && chip_idx == '0;
`ifdef PRNG_GOLD_BIT_SYNC_EN
  logic [4:0] epoch_cnt;
  always_ff @(posedge clk_in) begin
    if (rst_in || tap_load_in) epoch_cnt <= '0;
    else if (ena_in && wrap) epoch_cnt <= (epoch_cnt == 5'd19) ? 5'd0 : epoch_cnt + 5'd1;
  end
  assign bit_start_out = epoch_out && epoch_cnt == '0;
`else
  assign bit_start_out = 1'b0;
`endif
endmodule

// File: tb/tb_prng_gold.sv
// tb_prng_gold: scoreboard bench for prng_gold (default instance plus a CODE_LEN=4 instance).
module tb_prng_gold;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_a, ena_a, ld_a, rst_b, ena_b, ld_b;
  logic [4:0] ta, tb;
  logic       chip_a, chip_b, ep_a, ep_b, bs_a, bs_b;
  logic [3:0] sg_a, sg_b;
  logic [9:0] idx_a, idx_b;
  prng_gold dut (
    .clk_in(clk), .rst_in(rst_a), .ena_in(ena_a), .tap_load_in(ld_a),
    .tap_a_in(ta), .tap_b_in(tb), .chip_out(chip_a), .chip_signed_out(sg_a),
    .chip_idx_out(idx_a), .epoch_out(ep_a), .bit_start_out(bs_a)
  );
  prng_gold #(.CODE_LEN(4)) dut4 (
    .clk_in(clk), .rst_in(rst_b), .ena_in(ena_b), .tap_load_in(ld_b),
    .tap_a_in(ta), .tap_b_in(tb), .chip_out(chip_b), .chip_signed_out(sg_b),
    .chip_idx_out(idx_b), .epoch_out(ep_b), .bit_start_out(bs_b)
  );
  typedef struct {
    bit         sel;
    bit [3:0]   care;
    logic       chip;
    logic [9:0] idx;
    logic       ep;
    logic       bs;
    string      name;
  } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0;
  bit bs_chk;
  logic [9:0] prn1, prn2;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input bit sel, input bit [3:0] care, input logic chip, input int idx,
                      input logic ep, input logic bs, input string name);
    exp_t e;
    e.sel  = sel;
    e.care = care | (bs_chk ? 4'b1000 : 4'b0000);
    e.chip = chip;
    e.idx  = 10'(idx);
    e.ep   = ep;
    e.bs   = bs;
    e.name = name;
    sbq.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t       e;
    logic       c, ep, bs;
    logic [3:0] s;
    logic [9:0] ix;
    if (sbq.size() != 0) begin
      e  = sbq.pop_front();
      c  = e.sel ? chip_b : chip_a;
      s  = e.sel ? sg_b : sg_a;
      ix = e.sel ? idx_b : idx_a;
      ep = e.sel ? ep_b : ep_a;
      bs = e.sel ? bs_b : bs_a;
      if (e.care[0]) begin
        checks++;
        if (c !== e.chip || s !== (e.chip ? 4'hF : 4'h1)) begin
          errors++;
          $display("FAIL %s chip: got %b signed %h, expected %b signed %h", e.name, c, s, e.chip, e.chip ? 4'hF : 4'h1);
        end
      end
      if (e.care[1]) begin
        checks++;
        if (ix !== e.idx) begin
          errors++;
          $display("FAIL %s idx: got %0d, expected %0d", e.name, ix, e.idx);
        end
      end
      if (e.care[2]) begin
        checks++;
        if (ep !== e.ep) begin
          errors++;
          $display("FAIL %s epoch: got %b, expected %b", e.name, ep, e.ep);
        end
      end
      if (e.care[3]) begin
        checks++;
        if (bs !== e.bs) begin
          errors++;
          $display("FAIL %s bit_start: got %b, expected %b", e.name, bs, e.bs);
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    bit s;
    int k;
    prn1 = 10'b1100100000;
    prn2 = 10'b1110010000;
`ifdef PRNG_GOLD_BIT_SYNC_EN
    bs_chk = 1'b0;
`else
    bs_chk = 1'b1;
`endif
    {ena_a, ld_a, ena_b, ld_b} = '0;
    ta = 5'd0;
    tb = 5'd0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    push(0, 4'b0111, 1'b1, 0, 1'b0, 1'b0, "reset_idle");
    tick();
    ena_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(0, 4'b0111, prn1[9-i], i, i == 0, 1'b0, "prn1");
      tick();
    end
    for (int i = 10; i < 500; i++) begin
      push(0, 4'b0110, 1'b0, i, 1'b0, 1'b0, "run500");
      tick();
    end
    ld_a = 1'b1;
    ta = 5'd3;
    tb = 5'd7;
    push(0, 4'b0110, 1'b0, 500, 1'b0, 1'b0, "load_cycle");
    tick();
    ld_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(0, 4'b0111, prn2[9-i], i, i == 0, 1'b0, "prn2");
      tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      k = i % 1023;
      s = k < 10 ? prn1[9-k] : 1'b0;
      push(0, k < 10 ? 4'b0111 : 4'b0110, s, k, k == 0, 1'b0, "period");
      tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    push(0, 4'b0111, 1'b1, 0, 1'b1, 1'b0, "tog_en1");
    tick();
    ena_a = 1'b0;
    push(0, 4'b0111, 1'b1, 1, 1'b0, 1'b0, "tog_hold1");
    tick();
    push(0, 4'b0111, 1'b1, 1, 1'b0, 1'b0, "tog_hold2");
    tick();
    ena_a = 1'b1;
    push(0, 4'b0111, 1'b1, 1, 1'b0, 1'b0, "tog_en2");
    tick();
    push(0, 4'b0111, 1'b0, 2, 1'b0, 1'b0, "tog_after");
    tick();
    ena_a = 1'b0;
    ena_b = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push(1, 4'b0111, prn1[9-(i%4)], i % 4, i % 4 == 0, 1'b0, "len4");
      tick();
    end
    rst_b = 1'b1;
    push(1, 4'b0111, 1'b0, 2, 1'b0, 1'b0, "len4_prerst");
    tick();
    rst_b = 1'b0;
    push(1, 4'b0111, 1'b1, 0, 1'b1, 1'b0, "len4_rst");
    tick();
    ena_b = 1'b0;
`ifdef PRNG_GOLD_BIT_SYNC_EN
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ena_a = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      push(0, 4'b1000, 1'b0, 0, 1'b0, i == 0, "bs_pre");
      tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 20462; i++) begin
      push(0, i % 1023 == 0 ? 4'b1110 : 4'b1000, 1'b0, i % 1023, 1'b1, i == 0 || i == 20460, "bs_run");
      tick();
    end
`endif
    for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
